rf_wport_arb: RTL and testbench

- Arbitrates the single GPR write port between the WB stage writeback bus and a long-latency result source (divider/multiplier GPR results, late load returns).
- Late results are buffered in a small in-order FIFO and drained in cycles where WB does not write.
- Provides a pending-register bitmap for ID hazard stalls and a stall request for the pipeline controller.

---
 rtl/rf_wport_arb_pkg.sv | 35 +++
 rtl/rf_wport_arb_lr_fifo.sv | 94 +++++++++
 rtl/rf_wport_arb.sv | 134 +++++++++++++
 tb/tb_rf_wport_arb.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wport_arb_pkg.sv
// Shared definitions for the GPR write-port arbiter.
//   - Layout of the WB-stage writeback bus {we, waddr[4:0], wdata[31:0]}.
//   - Late-result FIFO entry type {vld, waddr, wdata}.
//   - One-hot register decode helper used for the pending bitmap.
package rf_wport_arb_pkg;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned DATA_W = 32;

    // WB -> RF bus: {we, waddr, wdata}
    localparam int unsigned WB_TO_RF_WD  = 1 + REG_AW + DATA_W;
    localparam int unsigned WB_WE_BIT    = 37;
    localparam int unsigned WB_WADDR_MSB = 36;
    localparam int unsigned WB_WADDR_LSB = 32;
    localparam int unsigned WB_WDATA_MSB = 31;
    localparam int unsigned WB_WDATA_LSB = 0;

    // Late-result FIFO entry: {vld, waddr, wdata}
    localparam int unsigned LR_ENTRY_WD = 1 + REG_AW + DATA_W;

    typedef struct packed {
        logic              vld;
        logic [REG_AW-1:0] waddr;
        logic [DATA_W-1:0] wdata;
    } lr_entry_t;

    // One-hot decode of a GPR index; r0 is hardwired zero so never pending.
    function automatic logic [31:0] reg_onehot(input logic [REG_AW-1:0] addr);
        logic [31:0] oh;
        oh    = 32'd1 << addr;
        oh[0] = 1'b0;
        return oh;
    endfunction

endpackage

// File: rtl/rf_wport_arb_lr_fifo.sv
// In-order FIFO holding late GPR results until the write port is free.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   push_i, push_entry_i enqueue request (caller guarantees free slot) and entry
//   pop_i                drop the head entry
//   squash_i, squash_addr_i  clear vld of every stored entry targeting this register
//   head_o               head entry (meaningful when count_o != 0)
//   count_o              occupancy, one extra bit to distinguish full from empty
//   ent_vld_o, ent_addr_o  per-slot valid/address for the pending bitmap
module rf_wport_arb_lr_fifo
    import rf_wport_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           push_i,
    input  lr_entry_t                      push_entry_i,
    input  logic                           pop_i,
    input  logic                           squash_i,
    input  logic [REG_AW-1:0]              squash_addr_i,
    output logic [LR_ENTRY_WD-1:0]         head_o,
    output logic [$clog2(DEPTH):0]         count_o,
    output logic [DEPTH-1:0]               ent_vld_o,
    output logic [DEPTH-1:0][REG_AW-1:0]   ent_addr_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    lr_entry_t [DEPTH-1:0] mem_q, mem_d;
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       count_q, count_d;
    logic                  push_ok, pop_ok;

    assign push_ok = push_i && (count_q < CntW'(DEPTH));
    assign pop_ok  = pop_i && (count_q != '0);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CntW'(push_ok) - CntW'(pop_ok);

        if (squash_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (mem_q[i].waddr == squash_addr_i) begin
                    mem_d[i].vld = 1'b0;
                end
            end
        end

        // Free slots keep vld=0 so the pending bitmap can OR all slots blindly.
        if (pop_ok) begin
            mem_d[rd_ptr_q].vld = 1'b0;
            rd_ptr_d            = rd_ptr_q + PtrW'(1);
        end

        // The push slot is never the popped slot: a push needs a free slot and
        // a pop needs a stored one, so they coincide only when neither applies.
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_entry_i;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        ent_vld_o  = '0;
        ent_addr_o = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ent_vld_o[i]  = mem_q[i].vld;
            ent_addr_o[i] = mem_q[i].waddr;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/rf_wport_arb.sv
// GPR write-port arbiter between the WB writeback bus and late results.
// WB has absolute priority; late results queue in an in-order FIFO and drain
// in cycles where WB does not write. A WB write to register X squashes every
// queued late result for X, since those are older in program order.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   wb_to_rf_bus        {we, waddr, wdata} from the WB stage
//   lr_valid/lr_ready   late-result handshake, lr_waddr/lr_wdata payload
//   rf_we/waddr/wdata   regfile write port
//   arb_src             0=WB, 1=FIFO owns the port
//   rf_pending          registers with a live queued late write
//   stallreq_wport      freeze request: FIFO full or drain starved too long
//   fifo_count          FIFO occupancy (debug)
module rf_wport_arb
    import rf_wport_arb_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WB_TO_RF_WD-1:0]   wb_to_rf_bus,
    input  logic                     lr_valid,
    output logic                     lr_ready,
    input  logic [REG_AW-1:0]        lr_waddr,
    input  logic [DATA_W-1:0]        lr_wdata,
    output logic                     rf_we,
    output logic [REG_AW-1:0]        rf_waddr,
    output logic [DATA_W-1:0]        rf_wdata,
    output logic                     arb_src,
    output logic [31:0]              rf_pending,
    output logic                     stallreq_wport,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;
    localparam int unsigned StW  = $clog2(STARVE_MAX + 1);

    logic                     wb_we;
    logic [REG_AW-1:0]        wb_waddr;
    logic [DATA_W-1:0]        wb_wdata;
    logic                     wb_write;
    logic                     fifo_empty, fifo_full;
    logic                     push, pop;
    lr_entry_t                push_entry;
    lr_entry_t                head;
    logic [DEPTH-1:0]         ent_vld;
    logic [DEPTH-1:0][REG_AW-1:0] ent_addr;
    logic [StW-1:0]           starve_q, starve_d;

    assign wb_we    = wb_to_rf_bus[WB_WE_BIT];
    assign wb_waddr = wb_to_rf_bus[WB_WADDR_MSB:WB_WADDR_LSB];
    assign wb_wdata = wb_to_rf_bus[WB_WDATA_MSB:WB_WDATA_LSB];
    // Writes to r0 are no-ops and leave the port free for draining.
    assign wb_write = wb_we && (wb_waddr != '0);

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == CntW'(DEPTH));

    // Registered-state only: a same-cycle pop does not open a slot.
    assign lr_ready = !fifo_full;

    // r0 results are accepted but never stored.
    assign push = lr_valid && lr_ready && (lr_waddr != '0);
    assign pop  = !wb_write && !fifo_empty;

    always_comb begin
        push_entry.vld   = !(wb_write && (lr_waddr == wb_waddr));
        push_entry.waddr = lr_waddr;
        push_entry.wdata = lr_wdata;
    end

    rf_wport_arb_lr_fifo #(
        .DEPTH (DEPTH)
    ) u_lr_fifo (
        .clk_i         (clk),
        .rst_ni        (rst),
        .push_i        (push),
        .push_entry_i  (push_entry),
        .pop_i         (pop),
        .squash_i      (wb_write),
        .squash_addr_i (wb_waddr),
        .head_o        (head),
        .count_o       (fifo_count),
        .ent_vld_o     (ent_vld),
        .ent_addr_o    (ent_addr)
    );

    // Port mux. A squashed head still takes its drain slot, with rf_we=0.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        arb_src  = 1'b0;
        if (wb_write) begin
            rf_we    = 1'b1;
            rf_waddr = wb_waddr;
            rf_wdata = wb_wdata;
        end else if (!fifo_empty) begin
            rf_we    = head.vld;
            rf_waddr = head.waddr;
            rf_wdata = head.wdata;
            arb_src  = 1'b1;
        end
    end

    // Counts consecutive cycles where WB blocks a waiting drain.
    always_comb begin
        starve_d = '0;
        if (!fifo_empty && wb_write) begin
            starve_d = (starve_q == StW'(STARVE_MAX)) ? starve_q : starve_q + StW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    assign stallreq_wport = fifo_full || (starve_q == StW'(STARVE_MAX));

    always_comb begin
        rf_pending = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (ent_vld[i]) begin
                rf_pending = rf_pending | reg_onehot(ent_addr[i]);
            end
        end
    end

endmodule

// File: tb/tb_rf_wport_arb.sv
module tb_rf_wport_arb;

    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [37:0] wb_to_rf_bus = '0;
    logic        lr_valid = 1'b0;
    logic        lr_ready;
    logic [4:0]  lr_waddr = '0;
    logic [31:0] lr_wdata = '0;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        arb_src;
    logic [31:0] rf_pending;
    logic        stallreq_wport;
    logic [2:0]  fifo_count;

    rf_wport_arb #(
        .DEPTH      (DEPTH),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .wb_to_rf_bus   (wb_to_rf_bus),
        .lr_valid       (lr_valid),
        .lr_ready       (lr_ready),
        .lr_waddr       (lr_waddr),
        .lr_wdata       (lr_wdata),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .arb_src        (arb_src),
        .rf_pending     (rf_pending),
        .stallreq_wport (stallreq_wport),
        .fifo_count     (fifo_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: queue of late results in program order.
    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        logic        v;
    } ment_t;
    ment_t       q[$];
    int          starve_m = 0;
    logic [31:0] model_rf[32];
    logic [31:0] dut_rf[32];

    // Outputs sampled in the most recent step.
    logic        s_we, s_src, s_stall, s_ready;
    logic [4:0]  s_a;
    logic [31:0] s_d, s_pend;
    logic [2:0]  s_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive after the falling edge, sample 1ns later, compare
    // with the model, then advance the model to the next cycle.
    task automatic step(input logic wwe, input logic [4:0] wa, input logic [31:0] wd,
                        input logic lv, input logic [4:0] la, input logic [31:0] ld);
        logic        ww;
        logic        e_we, e_src;
        logic [4:0]  e_a;
        logic [31:0] e_d, e_pend;
        int          sz;
        @(negedge clk);
        wb_to_rf_bus = {wwe, wa, wd};
        lr_valid     = lv;
        lr_waddr     = la;
        lr_wdata     = ld;
        #1;
        s_we = rf_we; s_a = rf_waddr; s_d = rf_wdata; s_src = arb_src;
        s_pend = rf_pending; s_stall = stallreq_wport; s_ready = lr_ready; s_cnt = fifo_count;

        ww = wwe && (wa != 0);
        sz = q.size();
        e_we = 0; e_a = 0; e_d = 0; e_src = 0;
        if (ww) begin
            e_we = 1; e_a = wa; e_d = wd;
        end else if (sz > 0) begin
            e_we = q[0].v; e_a = q[0].a; e_d = q[0].d; e_src = 1;
        end
        e_pend = 0;
        foreach (q[i]) if (q[i].v) e_pend[q[i].a] = 1'b1;
        e_pend[0] = 1'b0;

        check("rf_we",      s_we,    e_we);
        check("rf_waddr",   s_a,     e_a);
        check("rf_wdata",   s_d,     e_d);
        check("arb_src",    s_src,   e_src);
        check("rf_pending", s_pend,  e_pend);
        check("stallreq",   s_stall, (sz == DEPTH) || (starve_m == STARVE_MAX));
        check("lr_ready",   s_ready, sz < DEPTH);
        check("fifo_count", s_cnt,   sz);

        if (s_we) dut_rf[s_a] = s_d;

        if (ww) begin
            model_rf[wa] = wd;
            foreach (q[i]) if (q[i].a == wa) q[i].v = 1'b0;
        end else if (sz > 0) begin
            if (q[0].v) model_rf[q[0].a] = q[0].d;
            void'(q.pop_front());
        end
        if (lv && sz < DEPTH && la != 0) q.push_back('{a: la, d: ld, v: !(ww && la == wa)});
        starve_m = (sz > 0 && ww) ? ((starve_m + 1 > STARVE_MAX) ? STARVE_MAX : starve_m + 1) : 0;
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    // Asynchronous reset mid-cycle; outputs must clear without a clock edge.
    task automatic async_reset();
        @(negedge clk);
        wb_to_rf_bus = '0;
        lr_valid     = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("rst_count",   fifo_count,     3'd0);
        check("rst_pending", rf_pending,     32'd0);
        check("rst_ready",   lr_ready,       1'b1);
        check("rst_we",      rf_we,          1'b0);
        check("rst_waddr",   rf_waddr,       5'd0);
        check("rst_wdata",   rf_wdata,       32'd0);
        check("rst_src",     arb_src,        1'b0);
        check("rst_stall",   stallreq_wport, 1'b0);
        q.delete();
        starve_m = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    typedef struct {
        logic        wwe; logic [4:0] wa; logic [31:0] wd;
        logic        lv;  logic [4:0] la; logic [31:0] ld;
        logic        e_we; logic [4:0] e_a; logic [31:0] e_d; logic e_src;
        logic [2:0]  e_cnt; logic [31:0] e_pend; logic e_stall; logic e_ready;
    } vec_t;
    vec_t tbl[16];

    initial begin
        //              wwe wa  wd        lv la  ld        we a  d         src cnt pend        st rdy
        tbl[0]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 3'd0, 32'h0,     1'b0, 1'b1};
        tbl[1]  = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0,    1'b0, 3'd0, 32'h0,     1'b0, 1'b1};
        tbl[2]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b1, 5'd5, 32'h1234, 1'b1, 3'd1, 32'h20,    1'b0, 1'b1};
        tbl[3]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 3'd0, 32'h0,     1'b0, 1'b1};
        tbl[4]  = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd0, 32'hdead, 1'b0, 5'd0, 32'h0,    1'b0, 3'd0, 32'h0,     1'b0, 1'b1};
        tbl[5]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 3'd0, 32'h0,     1'b0, 1'b1};
        tbl[6]  = '{1'b1, 5'd4, 32'h44,   1'b1, 5'd4, 32'h55,   1'b1, 5'd4, 32'h44,   1'b0, 3'd0, 32'h0,     1'b0, 1'b1};
        tbl[7]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd4, 32'h55,   1'b1, 3'd1, 32'h0,     1'b0, 1'b1};
        tbl[8]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 3'd0, 32'h0,     1'b0, 1'b1};
        tbl[9]  = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd9, 32'h11,   1'b0, 5'd0, 32'h0,    1'b0, 3'd0, 32'h0,     1'b0, 1'b1};
        tbl[10] = '{1'b1, 5'd9, 32'h22,   1'b0, 5'd0, 32'h0,    1'b1, 5'd9, 32'h22,   1'b0, 3'd1, 32'h200,   1'b0, 1'b1};
        tbl[11] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd9, 32'h11,   1'b1, 3'd1, 32'h0,     1'b0, 1'b1};
        tbl[12] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 3'd0, 32'h0,     1'b0, 1'b1};
        tbl[13] = '{1'b1, 5'd0, 32'hff,   1'b1, 5'd2, 32'h77,   1'b0, 5'd0, 32'h0,    1'b0, 3'd0, 32'h0,     1'b0, 1'b1};
        tbl[14] = '{1'b1, 5'd0, 32'hff,   1'b0, 5'd0, 32'h0,    1'b1, 5'd2, 32'h77,   1'b1, 3'd1, 32'h4,     1'b0, 1'b1};
        tbl[15] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 3'd0, 32'h0,     1'b0, 1'b1};

        for (int i = 0; i < 32; i++) begin
            model_rf[i] = '0;
            dut_rf[i]   = '0;
        end

        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Directed vectors from the reset state.
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].wwe, tbl[i].wa, tbl[i].wd, tbl[i].lv, tbl[i].la, tbl[i].ld);
            check($sformatf("vec%0d_we", i),    s_we,    tbl[i].e_we);
            check($sformatf("vec%0d_waddr", i), s_a,     tbl[i].e_a);
            check($sformatf("vec%0d_wdata", i), s_d,     tbl[i].e_d);
            check($sformatf("vec%0d_src", i),   s_src,   tbl[i].e_src);
            check($sformatf("vec%0d_cnt", i),   s_cnt,   tbl[i].e_cnt);
            check($sformatf("vec%0d_pend", i),  s_pend,  tbl[i].e_pend);
            check($sformatf("vec%0d_stall", i), s_stall, tbl[i].e_stall);
            check($sformatf("vec%0d_ready", i), s_ready, tbl[i].e_ready);
        end
        check("final_r9", dut_rf[9], 32'h22);
        check("final_r4", dut_rf[4], 32'h44);
        check("final_r5", dut_rf[5], 32'h1234);

        // Starvation: WB holds the port until the starve limit forces a bubble.
        step(1'b1, 5'd3, 32'h300, 1'b1, 5'd7, 32'hA);
        for (int i = 0; i < STARVE_MAX; i++) begin
            step(1'b1, 5'd3, 32'h301 + i, 1'b0, 5'd0, 32'h0);
            check("starve_ready", s_ready, 1'b1);
            check("starve_nostall", s_stall, 1'b0);
        end
        idle();
        check("starve_stall", s_stall, 1'b1);
        check("starve_drain_we", s_we, 1'b1);
        check("starve_drain_addr", s_a, 5'd7);
        idle();
        check("starve_drop", s_stall, 1'b0);
        check("starve_r7", dut_rf[7], 32'hA);

        // Fill to DEPTH under WB pressure; a fifth offer is refused.
        for (int k = 0; k < DEPTH; k++) begin
            step(1'b1, 5'd3, 32'h400 + k, 1'b1, 5'(10 + k), 32'h100 + k);
            check("fill_ready", s_ready, 1'b1);
        end
        step(1'b1, 5'd3, 32'h410, 1'b1, 5'd20, 32'hBAD);
        check("full_ready", s_ready, 1'b0);
        check("full_stall", s_stall, 1'b1);
        step(1'b1, 5'd3, 32'h411, 1'b0, 5'd0, 32'h0);
        check("full_count", s_cnt, 3'd4);
        for (int k = 0; k < DEPTH; k++) begin
            idle();
            check("order_addr", s_a, 5'(10 + k));
            check("order_data", s_d, 32'h100 + k);
        end
        idle();
        check("drained_count", s_cnt, 3'd0);
        check("r20_untouched", dut_rf[20], 32'h0);

        // Reset with two entries queued.
        step(1'b1, 5'd3, 32'h500, 1'b1, 5'd14, 32'h14);
        step(1'b1, 5'd3, 32'h501, 1'b1, 5'd15, 32'h15);
        step(1'b1, 5'd3, 32'h502, 1'b0, 5'd0, 32'h0);
        check("pre_rst_count", s_cnt, 3'd2);
        async_reset();
        idle();
        check("post_rst_we", s_we, 1'b0);
        // Discarded entries were never written; the model regfile agrees.
        model_rf[14] = dut_rf[14];
        model_rf[15] = dut_rf[15];
        check("rst_discard_r14", dut_rf[14], 32'h0);

        // Random traffic with a stall controller that bubbles WB on request.
        for (int c = 0; c < 3000; c++) begin
            logic stall_m, wwe, lv;
            stall_m = (q.size() == DEPTH) || (starve_m == STARVE_MAX);
            wwe = ($urandom_range(0, 9) < 7) && !stall_m;
            lv  = $urandom_range(0, 1) == 1;
            step(wwe, 5'($urandom_range(0, 7)), $urandom, lv, 5'($urandom_range(0, 7)), $urandom);
            if (c == 1500) async_reset();
        end
        repeat (12) idle();

        for (int i = 1; i < 32; i++) begin
            check($sformatf("rf_r%0d", i), dut_rf[i], model_rf[i]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
